// File: rtl/mips_pkg.sv
// Shared write-back definitions: register-file geometry and the write entry
// carried through the load FIFO and onto the register-bank port.
package mips_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned WB_DW      = 32;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] wa;
        logic [WB_DW-1:0]      wd;
    } wb_entry_t;

    // Writes to r0 are architecturally discarded.
    function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] a);
        return a == ZERO_REG;
    endfunction

endpackage

// File: rtl/reg_writeback_if.sv
// Bundle of issue, ALU, load, register-port and scoreboard-query signals
// around the write-back stage.
interface reg_writeback_if #(
    parameter int unsigned DW = 32
);
    logic          iss_valid;
    logic [4:0]    iss_rd;

    logic          alu_valid;
    logic [4:0]    alu_wa;
    logic [DW-1:0] alu_wd;

    logic          mem_valid;
    logic          mem_ready;
    logic [4:0]    mem_wa;
    logic [DW-1:0] mem_wd;

    logic          RegWrite;
    logic [4:0]    WA;
    logic [DW-1:0] WD;

    logic [4:0]    qa1;
    logic [4:0]    qa2;
    logic          busy1;
    logic          busy2;

    // Write-back stage side.
    modport slave (
        input  iss_valid, iss_rd,
        input  alu_valid, alu_wa, alu_wd,
        input  mem_valid, mem_wa, mem_wd,
        output mem_ready,
        output RegWrite, WA, WD,
        input  qa1, qa2,
        output busy1, busy2
    );

    // Pipeline / register-bank side.
    modport master (
        output iss_valid, iss_rd,
        output alu_valid, alu_wa, alu_wd,
        output mem_valid, mem_wa, mem_wd,
        input  mem_ready,
        input  RegWrite, WA, WD,
        output qa1, qa2,
        input  busy1, busy2
    );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back entries holding load results that have not
// yet won the register write port.
module wb_fifo
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  wb_entry_t     i_entry,
    input  logic          i_pop,
    output wb_entry_t     o_head,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    wb_entry_t     r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    logic w_push_ok;
    logic w_pop_ok;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rptr];
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;

    // Storage array; contents are meaningless once the count is reset.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= i_entry;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap freely.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + AW'(1);
            end
            unique case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// Write-back stage: arbitrates ALU results and buffered load results onto the
// single register-bank write port and tracks pending writes per register.
module reg_writeback
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = WB_DW
) (
    input logic          clk,
    input logic          rst,
    reg_writeback_if.slave wb
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    wb_entry_t       w_mem_entry;
    wb_entry_t       w_fifo_head;
    wb_entry_t       w_win;
    logic            w_win_valid;
    logic            w_we;
    logic            w_mem_push;
    logic            w_fifo_pop;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic [CW-1:0]   w_fifo_count;
    logic            w_unused_count;

    logic                r_regwrite;
    logic [4:0]          r_wa;
    logic [DW-1:0]       r_wd;
    logic [NUM_REGS-1:0] r_sb;
    logic [NUM_REGS-1:0] w_sb_d;

    assign w_mem_entry    = '{wa: wb.mem_wa, wd: wb.mem_wd};
    // Ready depends only on registered occupancy; a same-cycle pop does not help.
    assign wb.mem_ready   = ~w_fifo_full;
    assign w_mem_push     = wb.mem_valid & ~w_fifo_full;
    assign w_unused_count = ^w_fifo_count;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_mem_push),
        .i_entry (w_mem_entry),
        .i_pop   (w_fifo_pop),
        .o_head  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // Fixed priority: ALU first (never stalled), then the oldest buffered load.
    always_comb begin
        w_win       = '0;
        w_win_valid = 1'b0;
        w_fifo_pop  = 1'b0;
        if (wb.alu_valid) begin
            w_win_valid = 1'b1;
            w_win       = '{wa: wb.alu_wa, wd: wb.alu_wd};
        end else if (!w_fifo_empty) begin
            w_win_valid = 1'b1;
            w_win       = w_fifo_head;
            w_fifo_pop  = 1'b1;
        end
        // An r0 winner is consumed but produces no write.
        w_we = w_win_valid & ~is_zero_reg(w_win.wa);
    end

    // Register-bank port; address/data hold when no write is presented.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_regwrite <= 1'b0;
            r_wa       <= '0;
            r_wd       <= '0;
        end else begin
            r_regwrite <= w_we;
            if (w_we) begin
                r_wa <= w_win.wa;
                r_wd <= w_win.wd;
            end
        end
    end

    assign wb.RegWrite = r_regwrite;
    assign wb.WA       = r_wa;
    assign wb.WD       = r_wd;

    // Scoreboard next state: clear on the registered write, then set on issue so set wins.
    always_comb begin
        w_sb_d = r_sb;
        if (w_we) begin
            w_sb_d[w_win.wa] = 1'b0;
        end
        if (wb.iss_valid && !is_zero_reg(wb.iss_rd)) begin
            w_sb_d[wb.iss_rd] = 1'b1;
        end
    end

    // Pending-write scoreboard state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sb <= '0;
        end else begin
            r_sb <= w_sb_d;
        end
    end

    assign wb.busy1 = r_sb[wb.qa1] & ~is_zero_reg(wb.qa1);
    assign wb.busy2 = r_sb[wb.qa2] & ~is_zero_reg(wb.qa2);

endmodule
